// File: rtl/kernel_conv_pkg.sv
// Shared definitions for the 3x3 convolution kernel unit.
//   ksel_e    : kernel select encoding
//   PIX_W     : pixel width, ROW_W : packed window-row width
//   window_t  : three packed rows, row 0 = top, left pixel in the row MSBs
//   pix()     : returns P(r,c) from a window
package kernel_pkg;

  localparam int PIX_W = 8;
  localparam int ROW_W = 3 * PIX_W;

  typedef enum logic [1:0] {
    K_BLUR    = 2'b00,
    K_SHARPEN = 2'b01,
    K_BOOST   = 2'b10,
    K_EDGE    = 2'b11
  } ksel_e;

  typedef logic [ROW_W-1:0] window_t [0:2];

  // Column 0 (left) sits in the most significant pixel slot of a row.
  function automatic logic [PIX_W-1:0] pix(input window_t win, input int r, input int c);
    logic [ROW_W-1:0] row;
    row = win[r];
    return row[(2-c)*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/kernel_conv_if.sv
// Window-in / result-out bundle for kernel_conv.
//   cache_in[0:2] : window rows from the line buffer
//   ksel          : kernel select, sampled with the window
//   in_valid      : window valid this cycle
//   kresult       : two's-complement result (OUT_W bits)
//   out_valid     : kresult updated this cycle
// master = window source, slave = kernel unit.
interface kernel_conv_if #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 16
);
  logic [3*PIX_W-1:0] cache_in [0:2];
  logic [1:0]         ksel;
  logic               in_valid;
  logic [OUT_W-1:0]   kresult;
  logic               out_valid;

  modport master (output cache_in, ksel, in_valid, input kresult, out_valid);
  modport slave  (input cache_in, ksel, in_valid, output kresult, out_valid);
endinterface

// File: rtl/kernel_conv_sums.sv
// Combinational neighbourhood sums for the 3x3 window.
//   cache_in : window rows (input)
//   c        : centre pixel P(1,1)
//   x4       : sum of the four edge-adjacent neighbours
//   s8       : sum of all eight non-centre pixels
// Widths are sized so no sum can overflow (8*255 = 2040 fits in PIX_W+3).
module kernel_sums
  import kernel_pkg::*;
(
  input  logic [ROW_W-1:0] cache_in [0:2],
  output logic [PIX_W-1:0] c,
  output logic [PIX_W+1:0] x4,
  output logic [PIX_W+2:0] s8
);

  window_t          win;
  logic [PIX_W+1:0] corners;

  always_comb begin
    win = cache_in;
    c   = pix(win, 1, 1);
    x4  = (PIX_W+2)'(pix(win, 0, 1)) + (PIX_W+2)'(pix(win, 1, 0))
        + (PIX_W+2)'(pix(win, 1, 2)) + (PIX_W+2)'(pix(win, 2, 1));
    corners = (PIX_W+2)'(pix(win, 0, 0)) + (PIX_W+2)'(pix(win, 0, 2))
            + (PIX_W+2)'(pix(win, 2, 0)) + (PIX_W+2)'(pix(win, 2, 2));
    s8  = (PIX_W+3)'(x4) + (PIX_W+3)'(corners);
  end

endmodule

// File: rtl/kernel_conv.sv
// 3x3 image-convolution kernel unit, single registered stage.
//   clk, rst : clock and asynchronous active-high reset
//   kif      : kernel_conv_if slave (window, ksel, in_valid -> kresult, out_valid)
// Kernels: 00 box blur (S8+C)/9, 01 sharpen 5C-X4, 10 high-boost 9C-S8,
// 11 Laplacian 4C-X4. Result is sign-extended to OUT_W.
// Optional build macro KERNEL_CLAMP_EN saturates the result to 0..255.
// PIX_W must match kernel_pkg::PIX_W (the window extractor lives there).
module kernel_conv #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 16
) (
  input logic          clk,
  input logic          rst,
  kernel_conv_if.slave kif
);
  import kernel_pkg::*;

  // 9*255 = 2295 needs 12 unsigned bits; one more for the sign.
  localparam int ACC_W = PIX_W + 5;

  logic [PIX_W-1:0] c;
  logic [PIX_W+1:0] x4;
  logic [PIX_W+2:0] s8;

  kernel_sums u_sums (
    .cache_in (kif.cache_in),
    .c        (c),
    .x4       (x4),
    .s8       (s8)
  );

  logic signed [ACC_W-1:0] c_s, x4_s, s8_s, raw, res;
  logic        [ACC_W-2:0] sum9, blur_q;

  always_comb begin
    c_s    = signed'(ACC_W'(c));
    x4_s   = signed'(ACC_W'(x4));
    s8_s   = signed'(ACC_W'(s8));
    sum9   = (ACC_W-1)'(s8) + (ACC_W-1)'(c);
    blur_q = sum9 / (ACC_W-1)'(9);
    raw    = '0;
    case (ksel_e'(kif.ksel))
      K_BLUR:    raw = signed'({1'b0, blur_q});
      K_SHARPEN: raw = (c_s <<< 2) + c_s - x4_s;
      K_BOOST:   raw = (c_s <<< 3) + c_s - s8_s;
      K_EDGE:    raw = (c_s <<< 2) - x4_s;
      default:   raw = '0;
    endcase
`ifdef KERNEL_CLAMP_EN
    if (raw < 0)
      res = '0;
    else if (raw > signed'(ACC_W'((1 << PIX_W) - 1)))
      res = signed'(ACC_W'((1 << PIX_W) - 1));
    else
      res = raw;
`else
    res = raw;
`endif
  end

  // Idle cycles drop out_valid but keep the last result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kif.kresult   <= '0;
      kif.out_valid <= 1'b0;
    end else begin
      kif.out_valid <= kif.in_valid;
      if (kif.in_valid)
        kif.kresult <= OUT_W'(res);
    end
  end

endmodule

// File: tb/tb_kernel_conv.sv
// Directed self-checking bench for kernel_conv; expected values are hand-computed.
// Build with +define+KERNEL_CLAMP_EN to check the saturating variant.
module tb_kernel_conv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  kernel_conv_if #(.PIX_W(8), .OUT_W(16)) kif ();

  kernel_conv #(.PIX_W(8), .OUT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h (%0d) expected 0x%04h (%0d)", tag, got, $signed(got), exp, $signed(exp));
    end
  endtask

  // Raw hand-computed value -> expected kresult for this build.
  function automatic logic [15:0] expv(input int raw);
`ifdef KERNEL_CLAMP_EN
    if (raw < 0) return 16'd0;
    if (raw > 255) return 16'd255;
`endif
    return 16'(raw);
  endfunction

  // px packs P00,P01,P02,P10,...,P22 from MSB to LSB (raster order).
  task automatic drive(input logic [71:0] px, input logic [1:0] k, input logic v);
    @(negedge clk);
    kif.cache_in[0] = px[71:48];
    kif.cache_in[1] = px[47:24];
    kif.cache_in[2] = px[23:0];
    kif.ksel        = k;
    kif.in_valid    = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] win(input logic [7:0] corner, input logic [7:0] edg,
                                      input logic [7:0] ctr);
    return {corner, edg, corner, edg, ctr, edg, corner, edg, corner};
  endfunction

  typedef struct {
    string       tag;
    logic [71:0] px;
    logic [1:0]  k;
    int          raw;
  } vec_t;

  vec_t vecs [$];

  initial begin
    kif.cache_in[0] = '0;
    kif.cache_in[1] = '0;
    kif.cache_in[2] = '0;
    kif.ksel        = 2'b00;
    kif.in_valid    = 1'b0;

    #1 rst = 1'b1;
    #1;
    check("reset_kresult", kif.kresult, 16'd0);
    check("reset_valid", {15'd0, kif.out_valid}, 16'd0);
    @(posedge clk);
    #1;
    check("reset_hold_valid", {15'd0, kif.out_valid}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{"blur_all11",     win(8'd11, 8'd11, 8'd11),    2'b00, 11});
    vecs.push_back('{"sharpen_c15",    win(8'd11, 8'd11, 8'd15),    2'b01, 31});
    vecs.push_back('{"boost_c22",      win(8'd11, 8'd11, 8'd22),    2'b10, 110});
    vecs.push_back('{"edge_all255",    win(8'd255, 8'd255, 8'd255), 2'b11, 0});
    vecs.push_back('{"boost_min",      win(8'd255, 8'd255, 8'd0),   2'b10, -2040});
    vecs.push_back('{"edge_min",       win(8'd255, 8'd255, 8'd0),   2'b11, -1020});
    vecs.push_back('{"sharpen_max",    win(8'd0, 8'd0, 8'd255),     2'b01, 1275});
    vecs.push_back('{"boost_max",      win(8'd0, 8'd0, 8'd255),     2'b10, 2295});
    vecs.push_back('{"blur_all255",    win(8'd255, 8'd255, 8'd255), 2'b00, 255});
    vecs.push_back('{"blur_trunc0",    win(8'd0, 8'd0, 8'd8),       2'b00, 0});
    vecs.push_back('{"blur_ce_sharp",  win(8'd10, 8'd20, 8'd30),    2'b00, 16});
    vecs.push_back('{"sharpen_ce",     win(8'd10, 8'd20, 8'd30),    2'b01, 70});
    vecs.push_back('{"boost_ce",       win(8'd10, 8'd20, 8'd30),    2'b10, 150});
    vecs.push_back('{"edge_ce",        win(8'd10, 8'd20, 8'd30),    2'b11, 40});
    vecs.push_back('{"edge_lr_asym",   {8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd100, 8'd0, 8'd0, 8'd0}, 2'b11, 100});
    vecs.push_back('{"boost_raster",   {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 2'b10, 4});
    vecs.push_back('{"blur_raster",    {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 2'b00, 4});

    // Back-to-back, in_valid held high throughout.
    foreach (vecs[i]) begin
      drive(vecs[i].px, vecs[i].k, 1'b1);
      check({vecs[i].tag, "_valid"}, {15'd0, kif.out_valid}, 16'd1);
      check(vecs[i].tag, kif.kresult, expv(vecs[i].raw));
    end

    // Idle: valid drops, result holds the last value (blur_raster = 4).
    drive({8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9}, 2'b01, 1'b0);
    check("idle_valid", {15'd0, kif.out_valid}, 16'd0);
    check("idle_hold", kif.kresult, 16'd4);
    drive(win(8'd0, 8'd0, 8'd0), 2'b10, 1'b0);
    check("idle_hold2", kif.kresult, 16'd4);

    // Mid-stream async reset.
    drive(win(8'd10, 8'd20, 8'd30), 2'b01, 1'b1);
    check("pre_rst", kif.kresult, expv(70));
    #2 rst = 1'b1;
    #1;
    check("async_rst_kresult", kif.kresult, 16'd0);
    check("async_rst_valid", {15'd0, kif.out_valid}, 16'd0);
    drive(win(8'd10, 8'd20, 8'd30), 2'b11, 1'b1);
    check("rst_held_kresult", kif.kresult, 16'd0);
    check("rst_held_valid", {15'd0, kif.out_valid}, 16'd0);
    #1 rst = 1'b0;
    #1;
    check("post_rst_kresult", kif.kresult, 16'd0);
    drive(win(8'd10, 8'd20, 8'd30), 2'b11, 1'b1);
    check("post_rst_first_valid", {15'd0, kif.out_valid}, 16'd1);
    check("post_rst_first", kif.kresult, expv(40));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kernel_conv.md
Name: kernel_conv

Overview:
- 3x3 image-convolution kernel unit in the execute stage.
- Takes a 3x3 window of 8-bit pixels from the cache/line buffer, applies one of four fixed kernels chosen by ksel, and produces one 16-bit result.
- Single-cycle registered datapath with a valid strobe.

Parameters:
- PIX_W, 8, pixel width in bits.
- OUT_W, 16, result width in bits; must be at least 13.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cache_in  input  3 x 24 (unpacked [0:2])  window rows.
  - Row 0 is top, row 2 is bottom.
  - Within a row, bits [23:16] are the left pixel, [15:8] the centre pixel, [7:0] the right pixel.
  - All pixels are unsigned.
- ksel  input  2  kernel select.
- in_valid  input  1  window and ksel are valid this cycle.
- kresult  output  OUT_W  convolution result, two's complement.
- out_valid  output  1  kresult is valid.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: kresult = 0 and out_valid = 0 immediately on rst assertion. Both stay 0 until the first clock edge after rst deasserts.
- Naming: P(r,c) is the pixel at row r, column c; C = P(1,1); S8 = sum of the 8 non-centre pixels; X4 = P(0,1)+P(1,0)+P(1,2)+P(2,1).
- ksel = 00, box blur: (S8 + C) / 9, unsigned division truncated toward zero. Range 0..255.
- ksel = 01, sharpen: 5*C - X4. Range -1020..1275.
- ksel = 10, high-boost: 9*C - S8. Range -2040..2295.
- ksel = 11, Laplacian edge: 4*C - X4. Range -1020..1020.
- Arithmetic: all intermediates are computed in at least 13-bit signed, with no overflow possible. The result is sign-extended to OUT_W.
- Latency: exactly 1 cycle. When in_valid is high at edge N, kresult and out_valid = 1 are updated at edge N.
- Idle cycles: when in_valid is low at an edge, out_valid goes to 0 and kresult holds its previous value.
- Throughput: one window per cycle. No backpressure.
- ksel is sampled in the same cycle as the window; changing ksel between cycles affects only the next sample.
- Reset mid-stream: the in-flight result is discarded; out_valid = 0.

Optional Feature:
- Macro: KERNEL_CLAMP_EN.
- When defined: the result is saturated to the 0..255 pixel range before registering (negative values become 0, values above 255 become 255). kresult upper bits are then zero.
- When not defined: the raw signed result is output (default).

Decomposition:
- Shared package kernel_pkg:
  - enum ksel_e: K_BLUR = 2'b00, K_SHARPEN = 2'b01, K_BOOST = 2'b10, K_EDGE = 2'b11.
  - Constants PIX_W and ROW_W = 3*PIX_W.
  - Pixel-extract function returning P(r,c).
- One natural sub-module, kernel_sums: a combinational block producing C, X4 and S8 from cache_in.
- Top level: kernel selection mux, divide-by-9, optional clamp, output register.

Test Plan:
- All pixels 11, ksel = 00, in_valid = 1 -> kresult = 11, out_valid = 1 after one edge.
- Pixels 11 with centre 15, ksel = 01 -> kresult = 31.
- Pixels 11 with centre 22, ksel = 10 -> kresult = 110 (22*9 - 11*8).
- All pixels 255, ksel = 11 -> kresult = 0. Centre 0 with others 255, ksel = 10 -> kresult = -2040 (0xF808); with KERNEL_CLAMP_EN -> 0.
- Pixels 0..8 in raster order, ksel = 00 -> 36/9 = 4. Then drop in_valid -> out_valid = 0 and kresult holds 4.
- Assert rst asynchronously mid-stream -> kresult = 0 and out_valid = 0 without waiting for a clock edge.
